alu_ctrl_pipe: RTL and testbench

//  Full-ISA ALU control stage for the MIPS core. Decodes instrD into the ALU op code and operand selects,

---
 rtl/alu_ctrl_pipe_pkg.sv | 80 ++++++++
 rtl/alu_ctrl_pipe_if.sv | 28 ++
 rtl/alu_ctrl_pipe_dec.sv | 52 +++++
 rtl/alu_ctrl_pipe.sv | 88 ++++++++
 tb/tb_alu_ctrl_pipe.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pipe_pkg.sv
// Shared ALU op codes, MIPS opcode/funct constants and ID/EX payload types
// for the ALU control stage.
package alu_ctrl_pipe_pkg;

    localparam int unsigned ALU_W = 5;

    // Long-standing codes keep their values; arithmetic, shift and mul/div codes follow them
    localparam logic [ALU_W-1:0] ALU_DEFAULT = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_AND     = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_OR      = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_XOR     = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_NOR     = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_LUI     = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_ADD     = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_ADDU    = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_SUB     = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_SUBU    = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_SLT     = ALU_W'(10);
    localparam logic [ALU_W-1:0] ALU_SLTU    = ALU_W'(11);
    localparam logic [ALU_W-1:0] ALU_SLL     = ALU_W'(12);
    localparam logic [ALU_W-1:0] ALU_SRL     = ALU_W'(13);
    localparam logic [ALU_W-1:0] ALU_SRA     = ALU_W'(14);
    localparam logic [ALU_W-1:0] ALU_SLLV    = ALU_W'(15);
    localparam logic [ALU_W-1:0] ALU_SRLV    = ALU_W'(16);
    localparam logic [ALU_W-1:0] ALU_SRAV    = ALU_W'(17);
    localparam logic [ALU_W-1:0] ALU_MULT    = ALU_W'(18);
    localparam logic [ALU_W-1:0] ALU_MULTU   = ALU_W'(19);
    localparam logic [ALU_W-1:0] ALU_DIV     = ALU_W'(20);
    localparam logic [ALU_W-1:0] ALU_DIVU    = ALU_W'(21);

    localparam logic [5:0] EXE_SPECIAL_OP = 6'b000000;
    localparam logic [5:0] EXE_ADDI_OP    = 6'b001000;
    localparam logic [5:0] EXE_ADDIU_OP   = 6'b001001;
    localparam logic [5:0] EXE_SLTI_OP    = 6'b001010;
    localparam logic [5:0] EXE_SLTIU_OP   = 6'b001011;
    localparam logic [5:0] EXE_ANDI_OP    = 6'b001100;
    localparam logic [5:0] EXE_ORI_OP     = 6'b001101;
    localparam logic [5:0] EXE_XORI_OP    = 6'b001110;
    localparam logic [5:0] EXE_LUI_OP     = 6'b001111;

    localparam logic [5:0] EXE_SLL   = 6'b000000;
    localparam logic [5:0] EXE_SRL   = 6'b000010;
    localparam logic [5:0] EXE_SRA   = 6'b000011;
    localparam logic [5:0] EXE_SLLV  = 6'b000100;
    localparam logic [5:0] EXE_SRLV  = 6'b000110;
    localparam logic [5:0] EXE_SRAV  = 6'b000111;
    localparam logic [5:0] EXE_MULT  = 6'b011000;
    localparam logic [5:0] EXE_MULTU = 6'b011001;
    localparam logic [5:0] EXE_DIV   = 6'b011010;
    localparam logic [5:0] EXE_DIVU  = 6'b011011;
    localparam logic [5:0] EXE_ADD   = 6'b100000;
    localparam logic [5:0] EXE_ADDU  = 6'b100001;
    localparam logic [5:0] EXE_SUB   = 6'b100010;
    localparam logic [5:0] EXE_SUBU  = 6'b100011;
    localparam logic [5:0] EXE_AND   = 6'b100100;
    localparam logic [5:0] EXE_OR    = 6'b100101;
    localparam logic [5:0] EXE_XOR   = 6'b100110;
    localparam logic [5:0] EXE_NOR   = 6'b100111;
    localparam logic [5:0] EXE_SLT   = 6'b101010;
    localparam logic [5:0] EXE_SLTU  = 6'b101011;

    typedef struct packed {
        logic [ALU_W-1:0] alu_ctrl;
        logic             imm_sel;
        logic             zero_ext;
        logic             shamt_sel;
        logic             md_op;
    } ctrl_t;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

    // Control word of an EX bubble
    function automatic ctrl_t ctrl_bubble();
        ctrl_t c;
        c          = '0;
        c.alu_ctrl = ALU_DEFAULT;
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// Decode-side inputs and EX-side control outputs of the ALU control stage.
interface alu_ctrl_pipe_if;
    import alu_ctrl_pipe_pkg::*;

    logic [31:0]      instrD;
    logic             validD;
    logic             stallE;
    logic             flushE;
    logic [ALU_W-1:0] alu_ctrlE;
    logic             imm_selE;
    logic             zero_extE;
    logic             shamt_selE;
    logic             md_opE;
    logic             validE;
    logic             md_stall;
    logic             md_done;

    modport master (
        output instrD, validD, stallE, flushE,
        input  alu_ctrlE, imm_selE, zero_extE, shamt_selE, md_opE, validE, md_stall, md_done
    );

    modport slave (
        input  instrD, validD, stallE, flushE,
        output alu_ctrlE, imm_selE, zero_extE, shamt_selE, md_opE, validE, md_stall, md_done
    );

endinterface

// File: rtl/alu_ctrl_pipe_dec.sv
// Combinational decode of opcode/funct into ALU op code, operand selects
// and the multi-cycle mul/div flag.
module alu_ctrl_dec
    import alu_ctrl_pipe_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = ctrl_bubble();
        case (op)
            EXE_SPECIAL_OP: begin
                case (funct)
                    EXE_ADD:   ctrl.alu_ctrl = ALU_ADD;
                    EXE_ADDU:  ctrl.alu_ctrl = ALU_ADDU;
                    EXE_SUB:   ctrl.alu_ctrl = ALU_SUB;
                    EXE_SUBU:  ctrl.alu_ctrl = ALU_SUBU;
                    EXE_AND:   ctrl.alu_ctrl = ALU_AND;
                    EXE_OR:    ctrl.alu_ctrl = ALU_OR;
                    EXE_XOR:   ctrl.alu_ctrl = ALU_XOR;
                    EXE_NOR:   ctrl.alu_ctrl = ALU_NOR;
                    EXE_SLT:   ctrl.alu_ctrl = ALU_SLT;
                    EXE_SLTU:  ctrl.alu_ctrl = ALU_SLTU;
                    EXE_SLLV:  ctrl.alu_ctrl = ALU_SLLV;
                    EXE_SRLV:  ctrl.alu_ctrl = ALU_SRLV;
                    EXE_SRAV:  ctrl.alu_ctrl = ALU_SRAV;
                    EXE_SLL:   begin ctrl.alu_ctrl = ALU_SLL;   ctrl.shamt_sel = 1'b1; end
                    EXE_SRL:   begin ctrl.alu_ctrl = ALU_SRL;   ctrl.shamt_sel = 1'b1; end
                    EXE_SRA:   begin ctrl.alu_ctrl = ALU_SRA;   ctrl.shamt_sel = 1'b1; end
                    EXE_MULT:  begin ctrl.alu_ctrl = ALU_MULT;  ctrl.md_op     = 1'b1; end
                    EXE_MULTU: begin ctrl.alu_ctrl = ALU_MULTU; ctrl.md_op     = 1'b1; end
                    EXE_DIV:   begin ctrl.alu_ctrl = ALU_DIV;   ctrl.md_op     = 1'b1; end
                    EXE_DIVU:  begin ctrl.alu_ctrl = ALU_DIVU;  ctrl.md_op     = 1'b1; end
                    default:   ;
                endcase
            end
            EXE_ADDI_OP:  begin ctrl.alu_ctrl = ALU_ADD;  ctrl.imm_sel = 1'b1; end
            EXE_ADDIU_OP: begin ctrl.alu_ctrl = ALU_ADDU; ctrl.imm_sel = 1'b1; end
            EXE_SLTI_OP:  begin ctrl.alu_ctrl = ALU_SLT;  ctrl.imm_sel = 1'b1; end
            EXE_SLTIU_OP: begin ctrl.alu_ctrl = ALU_SLTU; ctrl.imm_sel = 1'b1; end
            EXE_LUI_OP:   begin ctrl.alu_ctrl = ALU_LUI;  ctrl.imm_sel = 1'b1; end
            // Logical immediates are zero-extended
            EXE_ANDI_OP:  begin ctrl.alu_ctrl = ALU_AND; ctrl.imm_sel = 1'b1; ctrl.zero_ext = 1'b1; end
            EXE_ORI_OP:   begin ctrl.alu_ctrl = ALU_OR;  ctrl.imm_sel = 1'b1; ctrl.zero_ext = 1'b1; end
            EXE_XORI_OP:  begin ctrl.alu_ctrl = ALU_XOR; ctrl.imm_sel = 1'b1; ctrl.zero_ext = 1'b1; end
            default:      ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// ID/EX ALU control register with stall/flush and the MULT/DIV countdown
// sequencer that freezes upstream while a multi-cycle op occupies EX.
module alu_ctrl_pipe
    import alu_ctrl_pipe_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 34,
    parameter int unsigned CNT_W      = 6
) (
    input  logic            clk,
    input  logic            rst,
    alu_ctrl_pipe_if.slave  bus
);

    ctrl_t            dec_ctrl;
    ctrl_t            ctrl_q;
    logic             valid_q;
    md_state_t        state;
    logic [CNT_W-1:0] count;
    logic             md_active;
    logic             is_div;
    logic             md_stall;
    logic             md_done;
    logic             unused_bits;

    alu_ctrl_dec u_dec (
        .op    (bus.instrD[31:26]),
        .funct (bus.instrD[5:0]),
        .ctrl  (dec_ctrl)
    );

    // Register/shamt/immediate fields are consumed by the EX datapath, not here
    assign unused_bits = ^bus.instrD[25:6];

    assign md_active = valid_q & ctrl_q.md_op;
    assign is_div    = (ctrl_q.alu_ctrl == ALU_DIV) || (ctrl_q.alu_ctrl == ALU_DIVU);
    assign md_stall  = md_active & ((state == MD_IDLE) | ((state == MD_BUSY) & (count != '0)));
    assign md_done   = md_active & (state == MD_BUSY) & (count == '0);

    // EX register and mul/div sequencer
    always_ff @(posedge clk) begin
        if (rst || bus.flushE) begin
            ctrl_q  <= ctrl_bubble();
            valid_q <= 1'b0;
            state   <= MD_IDLE;
            count   <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (md_active) begin
                        state <= MD_BUSY;
                        count <= is_div ? CNT_W'(DIV_CYCLES - 2) : CNT_W'(MUL_CYCLES - 2);
                    end
                end
                MD_BUSY: begin
                    if (!md_active) begin
                        state <= MD_IDLE;
                    end else if (count != '0) begin
                        count <= count - CNT_W'(1);
                    end else begin
                        state <= bus.stallE ? MD_DONE : MD_IDLE;
                    end
                end
                MD_DONE: begin
                    if (!bus.stallE || !md_active) begin
                        state <= MD_IDLE;
                    end
                end
                default: state <= MD_IDLE;
            endcase

            if (!(bus.stallE || md_stall)) begin
                ctrl_q  <= dec_ctrl;
                valid_q <= bus.validD;
            end
        end
    end

    assign bus.alu_ctrlE  = ctrl_q.alu_ctrl;
    assign bus.imm_selE   = ctrl_q.imm_sel;
    assign bus.zero_extE  = ctrl_q.zero_ext;
    assign bus.shamt_selE = ctrl_q.shamt_sel;
    assign bus.md_opE     = ctrl_q.md_op;
    assign bus.validE     = valid_q;
    assign bus.md_stall   = md_stall;
    assign bus.md_done    = md_done;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Bench for alu_ctrl_pipe: table-driven decode reference plus an occupancy
// model of the EX slot, directed scenarios and a randomized run.
module tb_alu_ctrl_pipe;
    import alu_ctrl_pipe_pkg::*;

    typedef struct packed {
        logic [4:0] code;
        logic       imm;
        logic       zext;
        logic       shamt;
        logic       md;
    } exp_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        exp_t       d;
    } row_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_ctrl_pipe_if bus ();

    alu_ctrl_pipe #(.MUL_CYCLES(4), .DIV_CYCLES(34), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    row_t tab[$];

    // EX-slot model: what sits in EX, how many cycles it has been there, whether it finished
    exp_t m_ex;
    logic m_valid;
    int   m_age;
    int   m_n;
    bit   m_fin;

    int obs_code [128];
    int obs_valid[128];
    int obs_stall[128];
    int seq_stall_cnt, seq_done_cnt, seq_first_done, seq_last_done;

    task automatic add_row(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] code,
                           input logic imm, input logic zext, input logic shamt, input logic md);
        row_t r;
        r.op = op; r.fn = fn;
        r.d.code = code; r.d.imm = imm; r.d.zext = zext; r.d.shamt = shamt; r.d.md = md;
        tab.push_back(r);
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t e;
        e = '0;
        e.code = ALU_DEFAULT;
        foreach (tab[i])
            if (tab[i].op == ins[31:26] && (ins[31:26] != 6'd0 || tab[i].fn == ins[5:0]))
                e = tab[i].d;
        return e;
    endfunction

    function automatic int md_len(input exp_t d);
        return (d.code == ALU_DIV || d.code == ALU_DIVU) ? 34 : 4;
    endfunction

    function automatic logic exp_stall();
        return m_valid && m_ex.md && !m_fin && (m_age < m_n);
    endfunction

    function automatic logic exp_done();
        return m_valid && m_ex.md && !m_fin && (m_age == m_n);
    endfunction

    task automatic model_step(input logic [31:0] ins, input logic v, input logic st,
                              input logic fl, input logic r);
        logic hold;
        hold = st || exp_stall();
        if (r || fl) begin
            m_ex = '0; m_ex.code = ALU_DEFAULT; m_valid = 1'b0; m_age = 0; m_fin = 1'b0; m_n = 4;
        end else if (hold) begin
            if (m_valid && m_ex.md && !m_fin) begin
                if (m_age == m_n) m_fin = 1'b1;
                else              m_age++;
            end
        end else begin
            m_ex = ref_decode(ins); m_valid = v; m_age = 1; m_fin = 1'b0; m_n = md_len(m_ex);
        end
    endtask

    task automatic compare();
        logic [11:0] act, exp;
        act = {bus.alu_ctrlE, bus.imm_selE, bus.zero_extE, bus.shamt_selE, bus.md_opE,
               bus.validE, bus.md_stall, bus.md_done};
        exp = {m_ex, m_valid, exp_stall(), exp_done()};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%h want=%h", $time, act, exp);
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic cycle(input logic [31:0] ins, input logic v, input logic st,
                         input logic fl, input logic r);
        bus.instrD = ins; bus.validD = v; bus.stallE = st; bus.flushE = fl; rst = r;
        @(posedge clk);
        model_step(ins, v, st, fl, r);
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_seq(input logic [31:0] first, input logic [31:0] nxt, input int nobs,
                           input int st_lo, input int st_hi, input int fl_at,
                           input int rs_lo, input int rs_hi);
        seq_stall_cnt = 0; seq_done_cnt = 0; seq_first_done = 0; seq_last_done = 0;
        for (int k = 1; k <= nobs; k++) begin
            cycle((k == 1) ? first : nxt, 1'b1, (k >= st_lo && k <= st_hi), (k == fl_at),
                  (k >= rs_lo && k <= rs_hi));
            obs_code[k]  = int'(bus.alu_ctrlE);
            obs_valid[k] = int'(bus.validE);
            obs_stall[k] = int'(bus.md_stall);
            if (bus.md_stall) seq_stall_cnt++;
            if (bus.md_done) begin
                seq_done_cnt++;
                if (seq_first_done == 0) seq_first_done = k;
                seq_last_done = k;
            end
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'd0, 20'h12345, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op);
        return {op, 26'h2ABCDEF};
    endfunction

    task automatic check_ctrl(input string name, input logic [4:0] code, input logic imm,
                              input logic zext, input logic shamt);
        check(name, int'({bus.alu_ctrlE, bus.imm_selE, bus.zero_extE, bus.shamt_selE}),
              int'({code, imm, zext, shamt}));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        int idx;

        add_row(6'd0, 6'h20, ALU_ADD,   0, 0, 0, 0);  add_row(6'd0, 6'h21, ALU_ADDU,  0, 0, 0, 0);
        add_row(6'd0, 6'h22, ALU_SUB,   0, 0, 0, 0);  add_row(6'd0, 6'h23, ALU_SUBU,  0, 0, 0, 0);
        add_row(6'd0, 6'h24, ALU_AND,   0, 0, 0, 0);  add_row(6'd0, 6'h25, ALU_OR,    0, 0, 0, 0);
        add_row(6'd0, 6'h26, ALU_XOR,   0, 0, 0, 0);  add_row(6'd0, 6'h27, ALU_NOR,   0, 0, 0, 0);
        add_row(6'd0, 6'h2A, ALU_SLT,   0, 0, 0, 0);  add_row(6'd0, 6'h2B, ALU_SLTU,  0, 0, 0, 0);
        add_row(6'd0, 6'h00, ALU_SLL,   0, 0, 1, 0);  add_row(6'd0, 6'h02, ALU_SRL,   0, 0, 1, 0);
        add_row(6'd0, 6'h03, ALU_SRA,   0, 0, 1, 0);  add_row(6'd0, 6'h04, ALU_SLLV,  0, 0, 0, 0);
        add_row(6'd0, 6'h06, ALU_SRLV,  0, 0, 0, 0);  add_row(6'd0, 6'h07, ALU_SRAV,  0, 0, 0, 0);
        add_row(6'd0, 6'h18, ALU_MULT,  0, 0, 0, 1);  add_row(6'd0, 6'h19, ALU_MULTU, 0, 0, 0, 1);
        add_row(6'd0, 6'h1A, ALU_DIV,   0, 0, 0, 1);  add_row(6'd0, 6'h1B, ALU_DIVU,  0, 0, 0, 1);
        add_row(6'h08, 6'd0, ALU_ADD,   1, 0, 0, 0);  add_row(6'h09, 6'd0, ALU_ADDU,  1, 0, 0, 0);
        add_row(6'h0A, 6'd0, ALU_SLT,   1, 0, 0, 0);  add_row(6'h0B, 6'd0, ALU_SLTU,  1, 0, 0, 0);
        add_row(6'h0C, 6'd0, ALU_AND,   1, 1, 0, 0);  add_row(6'h0D, 6'd0, ALU_OR,    1, 1, 0, 0);
        add_row(6'h0E, 6'd0, ALU_XOR,   1, 1, 0, 0);  add_row(6'h0F, 6'd0, ALU_LUI,   1, 0, 0, 0);

        for (int i = 0; i < 3; i++) cycle(32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_code",  int'(bus.alu_ctrlE), int'(ALU_DEFAULT));
        check("reset_valid", int'(bus.validE), 0);
        check("reset_stall", int'(bus.md_stall), 0);
        idle(2);

        // Reset held two cycles in the middle of a DIV
        run_seq(rtype(6'h1A), rtype(6'h20), 12, 0, -1, 0, 11, 12);
        check("rst_div_stall_cnt", seq_stall_cnt, 10);
        check("rst_div_done_cnt",  seq_done_cnt, 0);
        check("rst_div_code",      obs_code[12], int'(ALU_DEFAULT));
        check("rst_div_valid",     obs_valid[12], 0);
        check("rst_div_mdstall",   obs_stall[12], 0);
        idle(2);

        // Back-to-back single-cycle ops
        cycle(itype(6'h08), 1'b1, 1'b0, 1'b0, 1'b0); check_ctrl("addi", ALU_ADD,  1, 0, 0);
        cycle(itype(6'h0D), 1'b1, 1'b0, 1'b0, 1'b0); check_ctrl("ori",  ALU_OR,   1, 1, 0);
        cycle(rtype(6'h00), 1'b1, 1'b0, 1'b0, 1'b0); check_ctrl("sll",  ALU_SLL,  0, 0, 1);
        cycle(rtype(6'h2B), 1'b1, 1'b0, 1'b0, 1'b0); check_ctrl("sltu", ALU_SLTU, 0, 0, 0);
        cycle(itype(6'h0F), 1'b1, 1'b0, 1'b0, 1'b0); check_ctrl("lui",  ALU_LUI,  1, 0, 0);
        idle(2);

        // MULT then ADD
        run_seq(rtype(6'h18), rtype(6'h20), 5, 0, -1, 0, 0, -1);
        check("mult_stall_cnt", seq_stall_cnt, 3);
        check("mult_done_at",   seq_first_done, 4);
        check("mult_done_cnt",  seq_done_cnt, 1);
        check("mult_add_in_ex", obs_code[5], int'(ALU_ADD));
        idle(2);

        // DIVU then DIV back to back
        run_seq(rtype(6'h1B), rtype(6'h1A), 68, 0, -1, 0, 0, -1);
        check("div2_done_cnt",   seq_done_cnt, 2);
        check("div2_first_done", seq_first_done, 34);
        check("div2_last_done",  seq_last_done, 68);
        check("div2_stall_cnt",  seq_stall_cnt, 66);
        check("div2_second_in",  obs_code[35], int'(ALU_DIV));
        idle(2);

        // MULT with external stall across its completion
        run_seq(rtype(6'h18), rtype(6'h20), 7, 4, 6, 0, 0, -1);
        check("mstall_done_cnt", seq_done_cnt, 1);
        check("mstall_done_at",  seq_first_done, 4);
        check("mstall_stall",    seq_stall_cnt, 3);
        check("mstall_held",     obs_code[6], int'(ALU_MULT));
        check("mstall_norestart", obs_stall[6], 0);
        check("mstall_release",  obs_code[7], int'(ALU_ADD));
        idle(2);

        // Flush during DIV countdown, then an unknown opcode
        run_seq(rtype(6'h1A), {6'b111111, 26'h0}, 26, 0, -1, 25, 0, -1);
        check("flush_done_cnt",  seq_done_cnt, 0);
        check("flush_stall_cnt", seq_stall_cnt, 24);
        check("flush_valid",     obs_valid[25], 0);
        check("flush_mdstall",   obs_stall[25], 0);
        check("unknown_code",    obs_code[26], int'(ALU_DEFAULT));
        check("unknown_valid",   obs_valid[26], 1);
        check_ctrl("unknown_sel", ALU_DEFAULT, 0, 0, 0);
        idle(2);

        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                ins = $urandom;
            end else begin
                idx = $urandom_range(0, tab.size() - 1);
                if (tab[idx].d.md && $urandom_range(0, 3) != 0)
                    idx = $urandom_range(0, 15);
                ins = $urandom;
                ins[31:26] = tab[idx].op;
                if (tab[idx].op == 6'd0) ins[5:0] = tab[idx].fn;
            end
            cycle(ins, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 4), ($urandom_range(0, 199) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
